// File: rtl/cipher_tx_sched_if.sv
// Handshake/data bundle between the two UART receivers, the UART transmitter and
// the cipher scheduler. The slave modport is the scheduler's view of the bundle.
interface cipher_tx_sched_if #(
    parameter int AW = 3
);
    logic          rx_done;
    logic [7:0]    rx_data;
    logic          key_done;
    logic [7:0]    key_data;
    logic          tx_active;
    logic          tx_done;
    logic          clr_ovf;
    logic          tx_start;
    logic [7:0]    tx_byte;
    logic          key_valid;
    logic [AW:0]   fifo_count;
    logic          overflow;
    logic [7:0]    last_plain;

    modport slave (
        input  rx_done, rx_data, key_done, key_data, tx_active, tx_done, clr_ovf,
        output tx_start, tx_byte, key_valid, fifo_count, overflow, last_plain
    );

    modport master (
        output rx_done, rx_data, key_done, key_data, tx_active, tx_done, clr_ovf,
        input  tx_start, tx_byte, key_valid, fifo_count, overflow, last_plain
    );
endinterface

// File: rtl/cipher_tx_sched.sv
// XOR-cipher UART scheduler: buffers plaintext in a FIFO and hands data^key to the
// transmitter one byte at a time. Define KEY_ROLL_EN for a rolling (rotating) key.
module cipher_tx_sched #(
    parameter int DEPTH       = 8,
    parameter int AW          = 3,
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    cipher_tx_sched_if.slave bus
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_START = 3'd2,
        S_ACK   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [7:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_count;
    logic [7:0]      r_key;
    logic            r_key_valid;
    logic            r_overflow;
    logic [7:0]      r_tx_byte;
    logic [7:0]      r_last_plain;
    logic            r_tx_start;
    logic [TW-1:0]   r_to_cnt;

    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;
    logic            w_drop;
    logic            w_to_hit;
    logic [7:0]      w_head;
    logic [7:0]      w_key_nxt;
    logic [AW:0]     w_count_nxt;

    assign w_full   = (r_count == (AW+1)'(DEPTH));
    assign w_empty  = (r_count == {(AW+1){1'b0}});
    assign w_pop    = (r_state == S_LOAD);
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign w_push   = bus.rx_done & (~w_full | w_pop);
    assign w_drop   = bus.rx_done & w_full & ~w_pop;
    assign w_head   = r_mem[r_rd_ptr];
    assign w_to_hit = (r_to_cnt == TW'(ACK_TIMEOUT - 1));

    // Next-state logic of the transmit sequencer.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_key_valid && !w_empty && !bus.tx_active) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD:  w_state_nxt = S_START;
            S_START: w_state_nxt = S_ACK;
            S_ACK: begin
                if (bus.tx_active) begin
                    w_state_nxt = S_DONE;
                end else if (w_to_hit) begin
                    w_state_nxt = S_START;
                end else begin
                    w_state_nxt = S_ACK;
                end
            end
            S_DONE: begin
                if (bus.tx_done) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Key register next value; a fresh key always wins over rotation.
    always_comb begin
        w_key_nxt = r_key;
        if (bus.key_done) begin
            w_key_nxt = bus.key_data;
        end else begin
`ifdef KEY_ROLL_EN
            if (w_pop) begin
                w_key_nxt = {r_key[6:0], r_key[7]};
            end else begin
                w_key_nxt = r_key;
            end
`else
            w_key_nxt = r_key;
`endif
        end
    end

    // Occupancy stays exact when push and pop coincide.
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + (AW+1)'(1);
            2'b01:   w_count_nxt = r_count - (AW+1)'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO storage; stale contents are unreachable once the pointers reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.rx_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
        end
    end

    // Key register and the sticky key-seen flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key       <= 8'h00;
            r_key_valid <= 1'b0;
        end else begin
            r_key <= w_key_nxt;
            if (bus.key_done) begin
                r_key_valid <= 1'b1;
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (bus.clr_ovf) begin
            r_overflow <= 1'b0;
        end
    end

    // Cipher byte capture at LOAD; held through retries until the next LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_byte    <= 8'h00;
            r_last_plain <= 8'h00;
        end else if (w_pop) begin
            r_tx_byte    <= w_head ^ r_key;
            r_last_plain <= w_head;
        end
    end

    // Start pulse coincides with the START state; ack timer runs only in ACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_start <= 1'b0;
            r_to_cnt   <= {TW{1'b0}};
        end else begin
            r_tx_start <= (w_state_nxt == S_START);
            if (r_state == S_ACK) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end else begin
                r_to_cnt <= {TW{1'b0}};
            end
        end
    end

    assign bus.tx_start   = r_tx_start;
    assign bus.tx_byte    = r_tx_byte;
    assign bus.key_valid  = r_key_valid;
    assign bus.fifo_count = r_count;
    assign bus.overflow   = r_overflow;
    assign bus.last_plain = r_last_plain;
endmodule

// File: tb/tb_cipher_tx_sched.sv
// Self-checking bench for cipher_tx_sched: directed cases plus a randomized phase
// scored against a queue-based model of the cipher stream (KEY_ROLL_EN aware).
module tb_cipher_tx_sched;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int TO    = 1023;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cipher_tx_sched_if #(.AW(AW)) bus ();

    cipher_tx_sched #(.DEPTH(DEPTH), .AW(AW), .ACK_TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_start = 0;
    int last_start_cyc = -1;
    int start_cycles[$];

    // Reference model: plaintext queue, key, overflow flag, bytes sent
    logic [7:0] m_q[$];
    logic [7:0] m_sent[$];
    logic [7:0] m_key = 8'h00;
    logic [7:0] m_cur = 8'h00;
    bit         m_busy = 1'b0;
    bit         m_ovf = 1'b0;
    bit         m_auto = 1'b0;
    bit         m_keyrand = 1'b0;
    int         rs_wait = 0;
    int         rs_act = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_key(input logic [7:0] k);
        bus.key_done = 1'b1;
        bus.key_data = k;
        m_key = k;
    endtask

    task automatic push(input logic [7:0] d);
        bus.rx_done = 1'b1;
        bus.rx_data = d;
        if (m_q.size() < DEPTH) m_q.push_back(d);
        else m_ovf = 1'b1;
    endtask

    task automatic clr();
        bus.clr_ovf = 1'b1;
        m_ovf = 1'b0;
    endtask

    // One clock: sample after the edge, score tx_start, run the transmitter model
    task automatic tick();
        logic [7:0] plain;
        @(posedge clk);
        #1;
        cyc++;
        bus.rx_done  = 1'b0;
        bus.key_done = 1'b0;
        bus.clr_ovf  = 1'b0;
        bus.tx_done  = 1'b0;
        if (bus.tx_start === 1'b1) begin
            n_start++;
            last_start_cyc = cyc;
            start_cycles.push_back(cyc);
            if (m_busy) begin
                chk("retry_tx_byte", bus.tx_byte, m_cur);
            end else begin
                chk("start_has_data", m_q.size() != 0, 1'b1);
                if (m_q.size() != 0) begin
                    plain = m_q.pop_front();
                    m_cur = plain ^ m_key;
                    chk("tx_byte", bus.tx_byte, m_cur);
                    chk("last_plain", bus.last_plain, plain);
                    m_sent.push_back(bus.tx_byte);
`ifdef KEY_ROLL_EN
                    m_key = {m_key[6:0], m_key[7]};
`endif
                    m_busy = 1'b1;
                    if (m_auto) begin
                        rs_wait = $urandom_range(1, 3);
                        if (m_keyrand && $urandom_range(0, 2) == 0)
                            send_key(8'($urandom_range(0, 255)));
                    end
                end
            end
        end else if (m_auto) begin
            if (rs_wait > 0) begin
                rs_wait--;
                if (rs_wait == 0) begin
                    bus.tx_active = 1'b1;
                    rs_act = $urandom_range(1, 4);
                end
            end else if (rs_act > 0) begin
                rs_act--;
                if (rs_act == 0) begin
                    bus.tx_active = 1'b0;
                    bus.tx_done   = 1'b1;
                    m_busy = 1'b0;
                end
            end
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_tx_start"}, bus.tx_start, 1'b0);
        chk({tag, "_tx_byte"}, bus.tx_byte, 8'h00);
        chk({tag, "_key_valid"}, bus.key_valid, 1'b0);
        chk({tag, "_fifo_count"}, bus.fifo_count, 4'd0);
        chk({tag, "_overflow"}, bus.overflow, 1'b0);
        chk({tag, "_last_plain"}, bus.last_plain, 8'h00);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #2;
        check_zero(tag);
        m_q.delete();
        m_sent.delete();
        start_cycles.delete();
        m_key = 8'h00;
        m_busy = 1'b0;
        m_ovf = 1'b0;
        m_auto = 1'b0;
        m_keyrand = 1'b0;
        rs_wait = 0;
        rs_act = 0;
        last_start_cyc = -1;
        bus.rx_done = 1'b0; bus.rx_data = 8'h00; bus.key_done = 1'b0; bus.key_data = 8'h00;
        bus.tx_active = 1'b0; bus.tx_done = 1'b0; bus.clr_ovf = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drain(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (m_q.size() == 0 && !m_busy) break;
            tick();
        end
        chk({tag, "_drained"}, (m_q.size() == 0 && !m_busy), 1'b1);
        tick();
        tick();
        chk({tag, "_count_empty"}, bus.fifo_count, 4'd0);
    endtask

    initial begin
        int c_rx;
        int s0;
        bus.rx_done = 1'b0; bus.rx_data = 8'h00; bus.key_done = 1'b0; bus.key_data = 8'h00;
        bus.tx_active = 1'b0; bus.tx_done = 1'b0; bus.clr_ovf = 1'b0;

        do_reset("rst0");

        // Case 1: key 0x5A, plaintext 0x3C -> 0x66 three cycles after rx_done
        m_auto = 1'b1;
        send_key(8'h5A);
        tick();
        chk("key_valid_set", bus.key_valid, 1'b1);
        c_rx = cyc;
        push(8'h3C);
        tick(); tick(); tick();
        chk("latency", last_start_cyc - c_rx, 3);
        chk("c1_tx_byte", bus.tx_byte, 8'h66);
        chk("c1_last_plain", bus.last_plain, 8'h3C);
        drain("c1", 100);

        // Randomized traffic with key changes during transfers
        m_keyrand = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0 && m_q.size() < DEPTH - 1)
                push(8'($urandom_range(0, 255)));
            tick();
        end
        drain("rand", 600);
        chk("rand_overflow", bus.overflow, m_ovf);
        chk("rand_key_valid", bus.key_valid, 1'b1);

        // Case 2: data before key stays buffered, then drains in order
        do_reset("rst2");
        m_auto = 1'b1;
        s0 = n_start;
        push(8'h11); tick();
        push(8'h22); tick();
        for (int i = 0; i < 6; i++) tick();
        chk("nokey_no_start", n_start - s0, 0);
        chk("nokey_count", bus.fifo_count, 4'd2);
        send_key(8'hFF);
        tick();
        drain("c2", 100);
        chk("c2_sent_n", m_sent.size(), 2);
        chk("c2_first", m_sent[0], 8'hEE);
        chk("c2_second", m_sent[1], 8'hDD);

        // Case 3: overflow with no key (nothing leaves the FIFO)
        do_reset("rst3");
        m_auto = 1'b1;
        for (int i = 0; i < DEPTH + 1; i++) begin
            push(8'($urandom_range(0, 255)));
            tick();
        end
        chk("full_count", bus.fifo_count, 4'd8);
        chk("ovf_set", bus.overflow, 1'b1);
        chk("ovf_model", bus.overflow, m_ovf);
        clr();
        push(8'h77);
        tick();
        chk("ovf_clr_and_drop", bus.overflow, 1'b1);
        clr();
        tick();
        chk("ovf_cleared", bus.overflow, 1'b0);

        // Case 4: full FIFO, push in the same cycle as the LOAD pop
        send_key(8'h3C);
        tick();
        tick();
        bus.rx_done = 1'b1;
        bus.rx_data = 8'hC3;
        m_q.push_back(8'hC3);
        tick();
        chk("pp_overflow", bus.overflow, 1'b0);
        chk("pp_count", bus.fifo_count, 4'd8);
        drain("c4", 400);

        // Case 5: tx_active never rises -> start re-issued with the same byte
        do_reset("rst5");
        send_key(8'hA5);
        tick();
        push(8'h10); tick();
        push(8'h20); tick();
        s0 = n_start;
        for (int i = 0; i < 3 * (TO + 1) + 40; i++) begin
            if (n_start - s0 >= 3) break;
            tick();
        end
        chk("retry_n", n_start - s0, 3);
        chk("retry_period1", start_cycles[1] - start_cycles[0], TO + 1);
        chk("retry_period2", start_cycles[2] - start_cycles[1], TO + 1);
        chk("retry_count", bus.fifo_count, 4'd1);
        chk("retry_byte_const", bus.tx_byte, 8'hB5);
        tick();
        do_reset("abort");

`ifdef KEY_ROLL_EN
        // Case 6: rolling key 0x81 over two zero bytes
        m_auto = 1'b1;
        send_key(8'h81);
        tick();
        push(8'h00); tick();
        push(8'h00); tick();
        drain("c6", 100);
        chk("roll_n", m_sent.size(), 2);
        chk("roll_first", m_sent[0], 8'h81);
        chk("roll_second", m_sent[1], 8'h03);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
